// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable frame format and exact baud timing
module uart_tx_fifo #(
  parameter int CLK_DIV    = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [AW:0]          fifo_count
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;
  state_t r_state, w_next;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] r_shift;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [BW-1:0] r_baud;
  logic [3:0] r_bit;
  logic r_par, r_tx, r_busy;
  logic w_empty, w_tick, w_pop, w_push, w_adv, w_tx;
  assign w_empty = r_cnt == '0;
  assign tx_ready = r_cnt != FULL;
  assign w_tick = r_baud == BAUD_MAX;
  // a full FIFO still takes a word on the edge that pops the head
  assign w_push = tx_valid && (tx_ready || w_pop);
  assign w_adv = w_pop || (r_state != IDLE && w_tick);
  assign w_tx = w_next == START ? 1'b0 :
                w_next == DATA ? (r_state == DATA ? r_shift[1] : r_shift[0]) :
                w_next == PAR_BIT ? r_par ^ (PARITY == 1) : 1'b1;
  assign uart_tx = r_tx;
  assign busy = r_busy;
  assign fifo_count = r_cnt;
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = !w_empty;
        w_next = w_empty ? IDLE : START;
      end
      START: w_next = w_tick ? DATA : START;
      DATA: if (w_tick && r_bit == 4'(DATA_BITS - 1)) w_next = PARITY != 0 ? PAR_BIT : STOP;
      PAR_BIT: w_next = w_tick ? STOP : PAR_BIT;
      STOP: if (w_tick && r_bit == 4'(STOP_BITS - 1)) begin
        w_pop = !w_empty;
        w_next = w_empty ? IDLE : START;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_par <= 1'b0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
      r_bit <= w_next != r_state ? '0 : r_bit + 4'(w_tick);
      r_tx <= w_adv ? w_tx : r_tx;
      r_busy <= w_next != IDLE;
      if (w_pop) begin
        r_shift <= r_mem[r_rp];
        r_par <= ^r_mem[r_rp];
      end else if (r_state == DATA && w_tick) r_shift <= r_shift >> 1;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four frame formats checked every cycle against a word-queue / line-timeline model
module tb_uart_tx_fifo;
  localparam int N = 4;
  localparam logic [N-1:0][7:0] CD_A = {8'd5, 8'd4, 8'd4, 8'd4};
  localparam logic [N-1:0][7:0] DB_A = {8'd5, 8'd8, 8'd8, 8'd8};
  localparam logic [N-1:0][7:0] PA_A = {8'd0, 8'd2, 8'd1, 8'd0};
  localparam logic [N-1:0][7:0] SB_A = {8'd2, 8'd1, 8'd1, 8'd1};
  localparam logic [N-1:0][7:0] FD_A = {8'd2, 8'd4, 8'd4, 8'd4};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] td [N];
  logic tv [N];
  logic tr [N];
  logic ut [N];
  logic bz [N];
  logic [6:0] fc [N];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [15:0] fbits(input logic [8:0] w, input int db, input int p, input int sb);
    logic [15:0] f = '0;
    int k = 1;
    logic x = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[k] = w[i];
      x ^= w[i];
      k++;
    end
    if (p != 0) begin
      f[k] = (p == 1) ? !x : x;
      k++;
    end
    for (int i = 0; i < sb; i++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction
  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h want %0h at %0t", nm, g, act, exp, $time);
    end
  endtask
  task automatic oops(input string nm, input int g);
    n_cmp++;
    n_bad++;
    $display("FAIL %s inst%0d: bound expired at %0t", nm, g, $time);
  endtask
  for (genvar g = 0; g < N; g++) begin : c
    localparam int CD = int'(CD_A[g]);
    localparam int DB = int'(DB_A[g]);
    localparam int PA = int'(PA_A[g]);
    localparam int SB = int'(SB_A[g]);
    localparam int FD = int'(FD_A[g]);
    localparam int AW = $clog2(FD);
    localparam int NB = 1 + DB + (PA != 0 ? 1 : 0) + SB;
    logic [AW:0] cnt;
    logic [8:0] q [$];
    bit ln [$];
    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PA), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(td[g][DB-1:0]), .tx_valid(tv[g]), .tx_ready(tr[g]),
      .uart_tx(ut[g]), .busy(bz[g]), .fifo_count(cnt));
    assign fc[g] = 7'(cnt);
    always @(posedge clk) begin : model
      bit full, popd;
      logic [15:0] f;
      if (!rst_n) begin
        q.delete();
        ln.delete();
      end else begin
        full = q.size() == FD;
        popd = 1'b0;
        if (ln.size() > 0) void'(ln.pop_front());
        if (ln.size() == 0 && q.size() > 0) begin
          f = fbits(q.pop_front(), DB, PA, SB);
          for (int b = 0; b < NB; b++) repeat (CD) ln.push_back(f[b]);
          popd = 1'b1;
        end
        if (tv[g] && (!full || popd)) q.push_back(td[g]);
      end
    end
    always @(negedge clk) begin : compare
      logic e_tx;
      if (chk_on) begin
        e_tx = 1'b1;
        if (ln.size() > 0) e_tx = ln[0];
        chk("uart_tx", g, ut[g], e_tx);
        chk("busy", g, bz[g], ln.size() > 0);
        chk("fifo_count", g, cnt, q.size());
        chk("tx_ready", g, tr[g], q.size() < FD);
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int g, input logic [8:0] w);
    int t = 0;
    td[g] = w;
    tv[g] = 1'b1;
    while (!tr[g] && t < 500) begin
      step();
      t++;
    end
    if (t == 500) oops("push_wait", g);
    step();
    tv[g] = 1'b0;
  endtask
  task automatic cap(input int g, input int n, output logic [63:0] s, output logic [63:0] b);
    s = '0;
    b = '0;
    for (int i = 0; i < n; i++) begin
      s[i] = ut[g];
      b[i] = bz[g];
      step();
    end
  endtask
  initial begin
    logic [63:0] s, b;
    int n;
    for (int i = 0; i < N; i++) begin
      td[i] = '0;
      tv[i] = 1'b0;
    end
    step(3);
    chk_on = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("rst_tx", i, ut[i], 1);
      chk("rst_busy", i, bz[i], 0);
      chk("rst_count", i, fc[i], 0);
      chk("rst_ready", i, tr[i], 1);
    end
    chk("model_55", 0, fbits(9'h55, 8, 0, 1), 16'h02AA);
    chk("model_07_odd", 1, fbits(9'h07, 8, 1, 1), 16'h040E);
    chk("model_07_even", 2, fbits(9'h07, 8, 2, 1), 16'h060E);
    chk("model_1f_5n2", 3, fbits(9'h1F, 5, 0, 2), 16'h00FE);
    rst_n = 1'b1;
    push(0, 9'h55);
    chk("latency_count", 0, fc[0], 1);
    step();
    cap(0, 40, s, b);
    chk("frame_55", 0, s[39:0], 40'hF0F0F0F0F0);
    chk("busy_55", 0, b[39:0], 40'hFFFFFFFFFF);
    chk("busy_end_55", 0, bz[0], 0);
    push(1, 9'h07);
    step();
    cap(1, 44, s, b);
    chk("frame_odd", 1, s[43:0], 44'hF000000FFF0);
    chk("busy_odd", 1, b[43:0], 44'hFFFFFFFFFFF);
    chk("busy_end_odd", 1, bz[1], 0);
    push(2, 9'h07);
    step();
    cap(2, 44, s, b);
    chk("frame_even", 2, s[43:0], 44'hFF00000FFF0);
    chk("busy_even", 2, b[43:0], 44'hFFFFFFFFFFF);
    chk("busy_end_even", 2, bz[2], 0);
    push(3, 9'h1F);
    step();
    cap(3, 40, s, b);
    chk("frame_5n2", 3, s[39:0], 40'hFFFFFFFFE0);
    chk("busy_5n2", 3, b[39:0], 40'hFFFFFFFFFF);
    chk("busy_end_5n2", 3, bz[3], 0);
    push(0, 9'h11);
    push(0, 9'h22);
    push(0, 9'h33);
    push(0, 9'h44);
    push(0, 9'h55);
    chk("b2b_full_count", 0, fc[0], 4);
    chk("b2b_full_ready", 0, tr[0], 0);
    td[0] = 9'h66;
    tv[0] = 1'b1;
    step(10);
    chk("held_count", 0, fc[0], 4);
    chk("held_ready", 0, tr[0], 0);
    step(27);
    chk("pop_push_count", 0, fc[0], 4);
    chk("pop_push_start", 0, ut[0], 0);
    chk("pop_push_busy", 0, bz[0], 1);
    tv[0] = 1'b0;
    n = 0;
    while (bz[0] && n < 1000) begin
      n++;
      step();
    end
    if (n == 1000) oops("drain", 0);
    chk("b2b_busy_cycles", 0, n, 200);
    chk("b2b_end_count", 0, fc[0], 0);
    push(0, 9'hA5);
    push(0, 9'h3C);
    push(0, 9'hC3);
    chk("queued_two", 0, fc[0], 2);
    step(16);
    chk("data_bit3", 0, ut[0], 0);
    rst_n = 1'b0;
    step();
    chk("abort_tx", 0, ut[0], 1);
    chk("abort_count", 0, fc[0], 0);
    chk("abort_busy", 0, bz[0], 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      n += int'(bz[0]);
      step();
    end
    chk("no_frames_after_abort", 0, n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
